// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, line levels and parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle between a byte producer and uart_tx.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_done;
    logic                 uart_tx;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  uart_tx
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output uart_tx
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter held at zero by clear; flags the last
// and second-to-last cycle of each bit period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end,
    output logic bit_near_end
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] NEAR_CNT = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] r_count;

    // Count clock cycles within a bit, wrapping at the end of each bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear || (r_count == LAST_CNT)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign bit_end      = (r_count == LAST_CNT);
    // Lets the FSM register tx_done so it lands exactly on the last stop cycle.
    assign bit_near_end = (r_count == NEAR_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional even
// parity (macro UART_TX_PARITY_EN), one stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int DATA_BITS    = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus
);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    uart_state_e          r_state;
    logic                 r_line;
    logic                 r_ready;
    logic                 r_done;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_clear;
    logic                 w_bit_end;
    logic                 w_bit_near_end;

`ifdef UART_TX_PARITY_EN
    logic       r_parity;
    logic [7:0] w_data_ext;

    // Zero-extend the payload so the shared 8-bit parity helper fits any width.
    always_comb begin
        w_data_ext                  = 8'h00;
        w_data_ext[DATA_BITS-1:0]   = bus.tx_data;
    end
`endif

    assign w_clear = (r_state == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (w_clear),
        .bit_end      (w_bit_end),
        .bit_near_end (w_bit_near_end)
    );

    // Frame sequencer with registered line, ready and done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_line   <= IDLE_LEVEL;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_idx    <= '0;
            r_shift  <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_line  <= IDLE_LEVEL;
                    r_ready <= 1'b1;
                    if (bus.tx_valid && r_ready) begin
                        r_shift  <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
                        r_parity <= even_parity(w_data_ext);
`endif
                        r_state  <= START;
                        r_line   <= START_LEVEL;
                        r_ready  <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_line  <= r_shift[0];
                        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_line  <= r_parity;
`else
                            r_state <= STOP;
                            r_line  <= STOP_LEVEL;
`endif
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_line  <= r_shift[0];
                            r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_line  <= STOP_LEVEL;
                    end
                end
`endif
                STOP: begin
                    r_done <= w_bit_near_end;
                    if (w_bit_end) begin
                        r_state <= IDLE;
                        r_line  <= IDLE_LEVEL;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_line  <= IDLE_LEVEL;
                    r_ready <= 1'b1;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign bus.uart_tx  = r_line;
    assign bus.tx_ready = r_ready;
    assign bus.tx_done  = r_done;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234: clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8: payload bits per frame; legal range 5..8.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port tx_data, input, DATA_BITS: byte to send; sampled only on accept.
REQ-006 SHALL have port tx_valid, input, 1: tx_data holds a byte to send.
REQ-007 SHALL have port tx_ready, output, 1: block will accept a byte this cycle.
REQ-008 SHALL have port tx_done, output, 1: one-cycle pulse when a frame's stop bit completes.
REQ-009 SHALL have port uart_tx, output, 1: serial line, idle high.

Function
REQ-010 SHALL accept a byte on a rising edge where tx_valid and tx_ready are both 1; tx_data is latched into an internal shift register on that edge.
REQ-011 SHALL ignore tx_valid while tx_ready is 0; no queuing, no error.
REQ-012 SHALL implement the states IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
REQ-013 SHALL drive tx_ready=1 only in IDLE.
REQ-014 SHALL drive uart_tx=0 in the cycle after accept, beginning START; latency from accept edge to the line falling is exactly 1 cycle.
REQ-015 SHALL hold each bit (start, each data bit, parity, stop) for exactly CLKS_PER_BIT cycles using a bit-timer counter of width $clog2(CLKS_PER_BIT).
REQ-016 SHALL send data LSB first, DATA_BITS bits, tracked by a bit index that wraps to 0 on leaving DATA.
REQ-017 SHALL drive uart_tx=1 for STOP; frame length without parity = (DATA_BITS+2)*CLKS_PER_BIT cycles.
REQ-018 SHALL pulse tx_done on the last STOP cycle and enter IDLE on the next edge; back-to-back frames have exactly 1 idle-high cycle between stop and next start.
REQ-019 SHALL keep the latched byte unaffected by tx_data changes after accept.
REQ-020 SHALL drive uart_tx=1 in IDLE and any illegal state encoding; illegal states return to IDLE on the next edge.

Reset
REQ-021 SHALL, while rst_n=0, force state=IDLE, uart_tx=1, tx_ready=1, tx_done=0, counter=0, bit index=0, shift register=0.
REQ-022 SHALL abort a frame in progress when reset is asserted mid-frame, with the line returning high asynchronously and no tx_done pulse.
REQ-023 SHALL allow a byte to be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with macro UART_TX_PARITY_EN defined, insert a PARITY state between DATA and STOP sending even parity (XOR of the data bits) for CLKS_PER_BIT cycles; frame = (DATA_BITS+3)*CLKS_PER_BIT.
REQ-025 SHALL, without UART_TX_PARITY_EN, contain no PARITY state or parity logic; DATA goes directly to STOP.

Structure
REQ-026 SHALL take the state encoding typedef (IDLE, START, DATA, PARITY, STOP) and the line levels IDLE_LEVEL=1, START_LEVEL=0 and STOP_LEVEL=1 from shared package uart_pkg, which the receiver also uses.
REQ-027 SHALL place the bit timer in sub-module uart_bit_timer (inputs clk, rst_n, clear; output bit_end when count==CLKS_PER_BIT-1), shareable with the receiver.

Verification (CLKS_PER_BIT=8, DATA_BITS=8)
REQ-028 SHALL check: accept 0x55 -> line low 8 cycles, then 1,0,1,0,1,0,1,0 for 8 cycles each, high 8 cycles; tx_done pulses once at cycle 80 after accept.
REQ-029 SHALL check: tx_valid held high with 0xA3 then 0x3C -> two frames separated by exactly 1 idle cycle; tx_ready is low for 80 cycles each.
REQ-030 SHALL check: tx_data changed to 0xFF 2 cycles after accepting 0x00 -> all data bits sent as 0.
REQ-031 SHALL check: rst_n pulsed low at cycle 30 of a frame -> uart_tx=1 immediately, no tx_done, tx_ready=1; a new frame starts cleanly on the next accept.
REQ-032 SHALL check, with UART_TX_PARITY_EN: 0x07 -> parity bit 1 and frame 88 cycles; 0x03 -> parity bit 0.
REQ-033 SHALL check: tx_valid pulsed mid-frame -> ignored, and no second frame follows.
